// File: rtl/router_pkg.sv
// Shared types and helpers for the router input/output controllers.
// Holds the FSM state encoding, header field layout and width helpers.
package router_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_EMPTY,
        S_LOAD_FIRST,
        S_LOAD_DATA,
        S_FIFO_FULL,
        S_LOAD_AFTER_FULL,
        S_LOAD_PARITY,
        S_CHECK_PARITY,
        S_DROP
    } state_e;

    // Destination address occupies the low bits of the header byte
    localparam int HDR_ADDR_LSB = 0;

    function automatic int addr_width(input int num_ports);
        return (num_ports > 2) ? $clog2(num_ports) : 1;
    endfunction

    function automatic int cnt_width(input int max_count);
        return (max_count > 0) ? $clog2(max_count + 1) : 1;
    endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR parity over a packet with load, accumulate and compare.
// Shared by the input and output sides of the router.
module router_parity_acc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic                  i_accum,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [DATA_WIDTH-1:0] i_cmp,
    output logic [DATA_WIDTH-1:0] o_acc,
    output logic                  o_match
);

    logic [DATA_WIDTH-1:0] r_acc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (i_load) begin
            r_acc <= i_data;
        end else if (i_accum) begin
            r_acc <= r_acc ^ i_data;
        end
    end

    assign o_acc   = r_acc;
    assign o_match = (r_acc == i_cmp);

endmodule

// File: rtl/router_input_ctrl.sv
// Per-input-port packet controller: decodes the header, streams the packet
// into the selected output FIFO, holds a byte across FIFO-full and checks parity.
module router_input_ctrl
    import router_pkg::*;
#(
    parameter  int DATA_WIDTH     = 8,
    parameter  int NUM_PORTS      = 3,
    parameter  int TIMEOUT_CYCLES = 30,
    localparam int ADDR_W         = addr_width(NUM_PORTS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_pkt_valid,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    input  logic [NUM_PORTS-1:0]  i_fifo_full,
    input  logic [NUM_PORTS-1:0]  i_fifo_empty,
    input  logic [NUM_PORTS-1:0]  i_soft_reset,
    output logic                  o_busy,
    output logic [NUM_PORTS-1:0]  o_wr_en,
    output logic [DATA_WIDTH-1:0] o_data_out,
    output logic [ADDR_W-1:0]     o_dest,
    output logic                  o_parity_err,
    output logic                  o_drop
);

    localparam int TCNT_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [ADDR_W:0]   NUM_P  = NUM_PORTS[ADDR_W:0];
    localparam logic [TCNT_W-1:0] T_MAX  = TCNT_W'(TIMEOUT_CYCLES);
    localparam logic [TCNT_W-1:0] T_LAST = (TIMEOUT_CYCLES > 0) ? TCNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_e                r_state;
    logic [ADDR_W-1:0]     r_dest;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [TCNT_W-1:0]     r_tcnt;
    logic                  r_drop;

    logic [ADDR_W-1:0]     w_addr;
    logic                  w_addr_ok;
    logic                  w_full;
    logic                  w_sr;
    logic                  w_sr_abort;
    logic                  w_sr_exit;
    logic                  w_timeout;
    logic [NUM_PORTS-1:0]  w_dest_oh;
    logic                  w_wr;
    logic [DATA_WIDTH-1:0] w_dout;
    logic                  w_par_load;
    logic                  w_par_accum;
    logic                  w_par_match;
    logic [DATA_WIDTH-1:0] w_par_acc;

    assign w_addr     = i_data_in[HDR_ADDR_LSB +: ADDR_W];
    assign w_addr_ok  = ({1'b0, w_addr} < NUM_P);
    assign w_full     = i_fifo_full[r_dest];
    assign w_sr       = i_soft_reset[r_dest];
    assign w_sr_abort = w_sr && (r_state inside {S_WAIT_EMPTY, S_LOAD_FIRST, S_LOAD_DATA,
                                                 S_FIFO_FULL, S_LOAD_AFTER_FULL});
    assign w_sr_exit  = w_sr && (r_state inside {S_LOAD_PARITY, S_CHECK_PARITY});
    assign w_timeout  = (TIMEOUT_CYCLES > 0) && (r_tcnt >= T_LAST);
    assign w_dest_oh  = {{(NUM_PORTS-1){1'b0}}, 1'b1} << r_dest;

    assign w_par_load  = (r_state == S_IDLE) && i_pkt_valid && w_addr_ok;
    assign w_par_accum = (r_state == S_LOAD_DATA) && i_pkt_valid && !w_sr;

    router_parity_acc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_par_load),
        .i_accum (w_par_accum),
        .i_data  (i_data_in),
        .i_cmp   (r_hold),
        .o_acc   (w_par_acc),
        .o_match (w_par_match)
    );

    // Write path: pass-through bytes go out in the cycle they are accepted
    always_comb begin
        w_wr   = 1'b0;
        w_dout = '0;
        case (r_state)
            S_LOAD_FIRST, S_LOAD_AFTER_FULL: begin
                w_wr   = 1'b1;
                w_dout = r_hold;
            end
            S_LOAD_DATA: begin
                if (i_pkt_valid && !w_full) begin
                    w_wr   = 1'b1;
                    w_dout = i_data_in;
                end
            end
            S_LOAD_PARITY: begin
                if (!w_full) begin
                    w_wr   = 1'b1;
                    w_dout = r_hold;
                end
            end
            default: ;
        endcase
        // A FIFO being flushed by soft_reset must not receive the aborted byte
        if (w_sr) begin
            w_wr   = 1'b0;
            w_dout = '0;
        end
    end

    assign o_wr_en      = w_wr ? w_dest_oh : '0;
    assign o_data_out   = w_dout;
    assign o_busy       = !(r_state inside {S_IDLE, S_LOAD_DATA, S_DROP});
    assign o_dest       = r_dest;
    assign o_parity_err = (r_state == S_CHECK_PARITY) && !w_sr && !w_par_match;
    assign o_drop       = r_drop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_dest  <= '0;
            r_hold  <= '0;
            r_tcnt  <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            if (w_sr_abort) begin
                r_state <= S_DROP;
                r_drop  <= 1'b1;
            end else if (w_sr_exit) begin
                r_state <= S_IDLE;
                r_drop  <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_pkt_valid) begin
                            if (!w_addr_ok) begin
                                r_state <= S_DROP;
                                r_drop  <= 1'b1;
                            end else begin
                                r_dest  <= w_addr;
                                r_hold  <= i_data_in;
                                r_tcnt  <= '0;
                                r_state <= i_fifo_empty[w_addr] ? S_LOAD_FIRST : S_WAIT_EMPTY;
                            end
                        end
                    end
                    S_WAIT_EMPTY: begin
                        // Empty takes precedence over an expiring timeout
                        if (i_fifo_empty[r_dest]) begin
                            r_state <= S_LOAD_FIRST;
                        end else if (w_timeout) begin
                            r_state <= S_DROP;
                            r_drop  <= 1'b1;
                        end else if (r_tcnt != T_MAX) begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
                    end
                    S_LOAD_FIRST: r_state <= S_LOAD_DATA;
                    S_LOAD_DATA: begin
                        if (!i_pkt_valid) begin
                            r_hold  <= i_data_in;
                            r_state <= S_LOAD_PARITY;
                        end else if (w_full) begin
                            r_hold  <= i_data_in;
                            r_state <= S_FIFO_FULL;
                        end
                    end
                    S_FIFO_FULL:       if (!w_full) r_state <= S_LOAD_AFTER_FULL;
                    S_LOAD_AFTER_FULL: r_state <= S_LOAD_DATA;
                    S_LOAD_PARITY:     if (!w_full) r_state <= S_CHECK_PARITY;
                    S_CHECK_PARITY:    r_state <= S_IDLE;
                    S_DROP:            if (!i_pkt_valid) r_state <= S_IDLE;
                    default:           r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_router_input_ctrl.sv
// Directed vector bench for router_input_ctrl with 3 destination FIFOs.
// Each record is one clock cycle: inputs applied, outputs expected in that cycle.
module tb_router_input_ctrl;

    logic       clk;
    logic       reset;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic       busy;
    logic [2:0] wr_en;
    logic [7:0] data_out;
    logic [1:0] dest;
    logic       parity_err;
    logic       drop;

    int total = 0;
    int bad   = 0;
    int tag   = 0;

    typedef struct {
        logic       pv;
        logic [7:0] d;
        logic [2:0] ff;
        logic [2:0] fe;
        logic [2:0] sr;
        logic       rn;
        logic       eb;
        logic [2:0] ew;
        logic [7:0] ed;
        logic       ep;
        logic       edr;
    } vec_t;

    vec_t tbl[$];

    router_input_ctrl #(
        .DATA_WIDTH     (8),
        .NUM_PORTS      (3),
        .TIMEOUT_CYCLES (30)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_pkt_valid  (pkt_valid),
        .i_data_in    (data_in),
        .i_fifo_full  (fifo_full),
        .i_fifo_empty (fifo_empty),
        .i_soft_reset (soft_reset),
        .o_busy       (busy),
        .o_wr_en      (wr_en),
        .o_data_out   (data_out),
        .o_dest       (dest),
        .o_parity_err (parity_err),
        .o_drop       (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic pv, input logic [7:0] d, input logic eb,
                                input logic [2:0] ew, input logic [7:0] ed,
                                input logic ep = 1'b0, input logic edr = 1'b0,
                                input logic [2:0] ff = 3'b000, input logic [2:0] fe = 3'b111,
                                input logic [2:0] sr = 3'b000, input logic rn = 1'b1);
        vec_t v;
        v.pv = pv; v.d = d; v.ff = ff; v.fe = fe; v.sr = sr; v.rn = rn;
        v.eb = eb; v.ew = ew; v.ed = ed; v.ep = ep; v.edr = edr;
        return v;
    endfunction

    task automatic cmp(input string what, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL vec%0d %s act=%0h req=%0h", tag, what, act, req);
        end
    endtask

    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        pkt_valid  = v.pv;
        data_in    = v.d;
        fifo_full  = v.ff;
        fifo_empty = v.fe;
        soft_reset = v.sr;
        reset      = v.rn;
        @(negedge clk);
        cmp("busy", {7'd0, busy}, {7'd0, v.eb});
        cmp("wr_en", {5'd0, wr_en}, {5'd0, v.ew});
        cmp("data_out", data_out, v.ed);
        cmp("parity_err", {7'd0, parity_err}, {7'd0, v.ep});
        cmp("drop", {7'd0, drop}, {7'd0, v.edr});
        tag++;
    endtask

    initial begin
        reset      = 1'b0;
        pkt_valid  = 1'b0;
        data_in    = 8'h00;
        fifo_full  = 3'b000;
        fifo_empty = 3'b111;
        soft_reset = 3'b000;
        repeat (2) @(posedge clk);

        // reset state
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 3'b000, 3'b111, 3'b000, 0));
        // basic packet 11 AA 55 / EE to FIFO 1
        tbl.push_back(mk(1, 8'h11, 0, 0, 0));
        tbl.push_back(mk(1, 8'hAA, 1, 3'b010, 8'h11));
        tbl.push_back(mk(1, 8'hAA, 0, 3'b010, 8'hAA));
        tbl.push_back(mk(1, 8'h55, 0, 3'b010, 8'h55));
        tbl.push_back(mk(0, 8'hEE, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 3'b010, 8'hEE));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0));
        // bad parity byte 00
        tbl.push_back(mk(1, 8'h11, 0, 0, 0));
        tbl.push_back(mk(1, 8'hAA, 1, 3'b010, 8'h11));
        tbl.push_back(mk(1, 8'hAA, 0, 3'b010, 8'hAA));
        tbl.push_back(mk(1, 8'h55, 0, 3'b010, 8'h55));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 3'b010, 8'h00));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0));
        // FIFO 1 full for 5 cycles starting while AA is presented
        tbl.push_back(mk(1, 8'h11, 0, 0, 0));
        tbl.push_back(mk(1, 8'hAA, 1, 3'b010, 8'h11));
        tbl.push_back(mk(1, 8'hAA, 0, 0, 0, 0, 0, 3'b010));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 8'h55, 1, 0, 0, 0, 0, 3'b010));
        tbl.push_back(mk(1, 8'h55, 1, 0, 0));
        tbl.push_back(mk(1, 8'h55, 1, 3'b010, 8'hAA));
        tbl.push_back(mk(1, 8'h55, 0, 3'b010, 8'h55));
        tbl.push_back(mk(0, 8'hEE, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 3'b010, 8'hEE));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0));
        // invalid address 03, then header 00 routes to FIFO 0
        tbl.push_back(mk(1, 8'h03, 0, 0, 0));
        tbl.push_back(mk(1, 8'hAA, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 8'h55, 0, 0, 0));
        tbl.push_back(mk(0, 8'hEE, 0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 8'h5A, 1, 3'b001, 8'h00));
        tbl.push_back(mk(1, 8'h5A, 0, 3'b001, 8'h5A));
        tbl.push_back(mk(0, 8'h5A, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 3'b001, 8'h5A));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0));
        // soft_reset[1] during LOAD_DATA discards the rest
        tbl.push_back(mk(1, 8'h11, 0, 0, 0));
        tbl.push_back(mk(1, 8'hAA, 1, 3'b010, 8'h11));
        tbl.push_back(mk(1, 8'hAA, 0, 3'b010, 8'hAA));
        tbl.push_back(mk(1, 8'h55, 0, 0, 0, 0, 0, 3'b000, 3'b111, 3'b010));
        tbl.push_back(mk(0, 8'hEE, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0));
        // reset low while in FIFO_FULL
        tbl.push_back(mk(1, 8'h11, 0, 0, 0));
        tbl.push_back(mk(1, 8'hAA, 1, 3'b010, 8'h11));
        tbl.push_back(mk(1, 8'hAA, 0, 0, 0, 0, 0, 3'b010));
        tbl.push_back(mk(1, 8'h55, 1, 0, 0, 0, 0, 3'b010));
        tbl.push_back(mk(1, 8'h55, 1, 0, 0, 0, 0, 3'b010, 3'b111, 3'b000, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 3'b001, 8'h00));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 3'b001, 8'h00));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0));

        foreach (tbl[i]) apply(tbl[i]);

        // timeout: FIFO 2 never empties, 30 wait cycles then DROP
        apply(mk(1, 8'h02, 0, 0, 0, 0, 0, 3'b000, 3'b011));
        for (int k = 1; k <= 30; k++) apply(mk(1, 8'hAA, 1, 0, 0, 0, 0, 3'b000, 3'b011));
        apply(mk(1, 8'hAA, 0, 0, 0, 0, 1, 3'b000, 3'b011));
        apply(mk(0, 8'hEE, 0, 0, 0, 0, 0, 3'b000, 3'b011));
        for (int k = 0; k < 7; k++) apply(mk(0, 8'h00, 0, 0, 0, 0, 0, 3'b000, 3'b011));

        // FIFO 2 empties on the 30th wait cycle: LOAD_FIRST wins
        apply(mk(1, 8'h02, 0, 0, 0, 0, 0, 3'b000, 3'b011));
        for (int k = 1; k <= 29; k++) apply(mk(1, 8'hAA, 1, 0, 0, 0, 0, 3'b000, 3'b011));
        apply(mk(1, 8'hAA, 1, 0, 0));
        apply(mk(0, 8'h02, 1, 3'b100, 8'h02));
        apply(mk(0, 8'h02, 0, 0, 0));
        apply(mk(0, 8'h00, 1, 3'b100, 8'h02));
        apply(mk(0, 8'h00, 1, 0, 0));
        apply(mk(0, 8'h00, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
